// File: rtl/multiport_memory_if.sv
// -----------------------------------------------------------------------------
// multiport_memory_if
//   Bundles the write port, the READ_PORTS read ports, ready and the debug
//   trace enable of multiport_memory. clk and reset stay plain module ports.
//
//   write_addr_in  [AW-1:0]               write word address
//   write_in                              write strobe
//   write_data_in  [W-1:0]                write data
//   write_mask_in  [MEM_WIDTH_BYTES-1:0]  per-byte write enable
//   read_addr_in   [READ_PORTS*AW-1:0]    port p address at [p*AW +: AW]
//   read_in        [READ_PORTS-1:0]       per-port read strobe
//   read_data_out  [READ_PORTS*W-1:0]     port p data at [p*W +: W]
//   read_valid_out [READ_PORTS-1:0]       port p data valid this cycle
//   ready_out                             array cleared, accepting traffic
//   debugen_in                            per-cycle trace enable
//
//   master: the pipeline stage driving the memory.  slave: the memory.
// -----------------------------------------------------------------------------
interface multiport_memory_if #(
   parameter int MEM_WIDTH_BYTES = 8,
   parameter int MEM_DEPTH       = 64,
   parameter int READ_PORTS      = 2
);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam int W  = MEM_WIDTH_BYTES * 8;

   logic [AW-1:0]              write_addr_in;
   logic                       write_in;
   logic [W-1:0]               write_data_in;
   logic [MEM_WIDTH_BYTES-1:0] write_mask_in;
   logic [READ_PORTS*AW-1:0]   read_addr_in;
   logic [READ_PORTS-1:0]      read_in;
   logic [READ_PORTS*W-1:0]    read_data_out;
   logic [READ_PORTS-1:0]      read_valid_out;
   logic                       ready_out;
   logic                       debugen_in;

   modport master (
      output write_addr_in, write_in, write_data_in, write_mask_in,
             read_addr_in, read_in, debugen_in,
      input  read_data_out, read_valid_out, ready_out
   );

   modport slave (
      input  write_addr_in, write_in, write_data_in, write_mask_in,
             read_addr_in, read_in, debugen_in,
      output read_data_out, read_valid_out, ready_out
   );
endinterface

// File: rtl/multiport_memory.sv
// -----------------------------------------------------------------------------
// multiport_memory
//   Byte-maskable RAM with one write port and READ_PORTS independent read
//   ports. Reads sample the array in the issue cycle (optionally forwarding a
//   same-address write) and deliver through a READ_LATENCY-deep per-port
//   pipeline. After reset an optional sequencer zeroes every word before
//   ready_out rises; until then all traffic is ignored.
//
//   clk    sole clock, all state updates on posedge
//   reset  synchronous, active-high
//   bus    multiport_memory_if.slave (write port, read ports, ready, trace)
// -----------------------------------------------------------------------------
module multiport_memory #(
   parameter int MEM_WIDTH_BYTES = 8,
   parameter int MEM_DEPTH       = 64,
   parameter int READ_PORTS      = 2,
   parameter int READ_LATENCY    = 1,
   parameter int BYPASS          = 1,
   parameter int CLEAR_ON_RESET  = 1
) (
   input  logic               clk,
   input  logic               reset,
   multiport_memory_if.slave  bus
);
   localparam int AW     = $clog2(MEM_DEPTH);
   localparam int W      = MEM_WIDTH_BYTES * 8;
   // Latency 0 still keeps one stage: it holds the last delivered word.
   localparam int STAGES = (READ_LATENCY == 0) ? 1 : READ_LATENCY;

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic [AW-1:0]         r_clr_addr;
   logic                  r_ready;
   logic [W-1:0]          r_mem [MEM_DEPTH];

   logic                  w_clr_last;
   logic                  w_wr_en;
   logic [W-1:0]          w_wr_bitmask;
   logic [W-1:0]          w_wr_old;
   logic [W-1:0]          w_wr_merged;
   logic [AW-1:0]         w_rd_addr   [READ_PORTS];
   logic [W-1:0]          w_rd_sample [READ_PORTS];
   logic [READ_PORTS-1:0] w_rd_issue;

   logic [READ_PORTS-1:0] r_pipe_vld [STAGES];
   logic [W-1:0]          r_pipe_dat [STAGES][READ_PORTS];

   // Depth need not be a power of two, so some encodable addresses are holes.
   function automatic logic in_range(input logic [AW-1:0] a);
      return (int'(a) < MEM_DEPTH);
   endfunction

   // ---------------------------------------------------------------- control
   assign w_clr_last = (r_clr_addr == AW'(MEM_DEPTH - 1));

   // NOTE: sequential state is assigned with <= so every flop samples the
   // values from before the edge, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      end else begin
         r_state <= w_state_next;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_CLEAR: if (w_clr_last) w_state_next = ST_READY;
         ST_READY: w_state_next = ST_READY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_clr_addr <= '0;
      end else if (r_state == ST_CLEAR && !w_clr_last) begin
         r_clr_addr <= r_clr_addr + AW'(1);
      end
   end

   // ready_out is cleared by reset even when no clear runs, so it rises only
   // on the first cycle after reset deasserts.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ready <= 1'b0;
      end else begin
         r_ready <= (w_state_next == ST_READY);
      end
   end

   assign bus.ready_out = r_ready;

   // ------------------------------------------------------------------ write
   always_comb begin
      w_wr_bitmask = '0;
      for (int b = 0; b < MEM_WIDTH_BYTES; b++) begin
         w_wr_bitmask[8*b +: 8] = {8{bus.write_mask_in[b]}};
      end
   end

   assign w_wr_en     = r_ready & bus.write_in & in_range(bus.write_addr_in);
   assign w_wr_old    = in_range(bus.write_addr_in) ? r_mem[bus.write_addr_in] : '0;
   assign w_wr_merged = (w_wr_old & ~w_wr_bitmask) | (bus.write_data_in & w_wr_bitmask);

   // NOTE: the array itself has no reset branch; zeroing is the clear
   // sequencer's job, which keeps the storage mappable onto RAM cells.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == ST_CLEAR) begin
            r_mem[r_clr_addr] <= '0;
         end else if (w_wr_en) begin
            r_mem[bus.write_addr_in] <= w_wr_merged;
         end
      end
   end

   // ------------------------------------------------------------------- read
   always_comb begin
      w_rd_issue = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         w_rd_addr[p]   = bus.read_addr_in[p*AW +: AW];
         w_rd_issue[p]  = r_ready & bus.read_in[p];
         w_rd_sample[p] = in_range(w_rd_addr[p]) ? r_mem[w_rd_addr[p]] : '0;
         // w_wr_en already excludes holes, so forwarding never leaks into them.
         if (BYPASS != 0 && w_wr_en && bus.write_addr_in == w_rd_addr[p]) begin
            w_rd_sample[p] = w_wr_merged;
         end
      end
   end

   // Each stage loads data only alongside a valid, so the last stage keeps
   // the most recent delivered word between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < STAGES; s++) begin
            r_pipe_vld[s] <= '0;
            for (int p = 0; p < READ_PORTS; p++) begin
               r_pipe_dat[s][p] <= '0;
            end
         end
      end else begin
         r_pipe_vld[0] <= w_rd_issue;
         for (int p = 0; p < READ_PORTS; p++) begin
            if (w_rd_issue[p]) r_pipe_dat[0][p] <= w_rd_sample[p];
         end
         for (int s = 1; s < STAGES; s++) begin
            r_pipe_vld[s] <= r_pipe_vld[s-1];
            for (int p = 0; p < READ_PORTS; p++) begin
               if (r_pipe_vld[s-1][p]) r_pipe_dat[s][p] <= r_pipe_dat[s-1][p];
            end
         end
      end
   end

   always_comb begin
      bus.read_valid_out = '0;
      bus.read_data_out  = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         if (READ_LATENCY == 0) begin
            bus.read_valid_out[p]       = w_rd_issue[p];
            bus.read_data_out[p*W +: W] = w_rd_issue[p] ? w_rd_sample[p] : r_pipe_dat[0][p];
         end else begin
            bus.read_valid_out[p]       = r_pipe_vld[STAGES-1][p];
            bus.read_data_out[p*W +: W] = r_pipe_dat[STAGES-1][p];
         end
      end
   end

   // ------------------------------------------------------------------ trace
   always_ff @(posedge clk) begin
      if (bus.debugen_in) begin
         $write("mpm t=%0t rdy=%0b wr=%0b wa=%0h wm=%0h wd=%0h", $time, r_ready,
                bus.write_in, bus.write_addr_in, bus.write_mask_in, bus.write_data_in);
         for (int p = 0; p < READ_PORTS; p++) begin
            $write(" | p%0d rd=%0b ra=%0h rv=%0b rq=%0h", p, bus.read_in[p], w_rd_addr[p],
                   bus.read_valid_out[p], bus.read_data_out[p*W +: W]);
         end
         $write("\n");
      end
   end
endmodule
